// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clocks per line bit; integer quotient, remainder discarded.
  function automatic int calc_div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; pushes on a full
// FIFO are dropped even when a pop happens on the same edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter fed by a byte FIFO: 8N1 frames, or 8E1 when
// UART_TX_PARITY_EN is defined. fsm_state exposes the FSM for debug.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int SYSTM_OPERN_FREQ = 11059200,
  parameter int REQD_BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            tx_data_byte,
  input  logic                         tx_data_valid,
  output logic                         tx_data_ready,
  output logic                         tx_ser_data_out,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [2:0]                   fsm_state
);

  localparam int DIV   = calc_div(SYSTM_OPERN_FREQ, REQD_BAUD_RATE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  tx_state_t         state, next_state;
  logic [CNT_W-1:0]  baud_cnt, next_cnt;
  logic [2:0]        bit_idx, next_bit;
  logic [DATA_W-1:0] shift_reg, next_shift;
  logic [DATA_W-1:0] head;
  logic              line_next;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              bit_done;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_data_valid),
    .push_data (tx_data_byte),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_data_ready = !fifo_full;
  assign tx_busy       = (state != ST_IDLE) || !fifo_empty;
  assign fsm_state     = state;
  assign bit_done      = (baud_cnt == LAST);

  // The line register follows the state one clock later, which gives the
  // two-clock push-to-start-bit latency and keeps every level DIV clocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      tx_ser_data_out <= 1'b1;
    end else begin
      state           <= next_state;
      baud_cnt        <= next_cnt;
      bit_idx         <= next_bit;
      shift_reg       <= next_shift;
      tx_ser_data_out <= line_next;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = bit_done ? '0 : baud_cnt + CNT_W'(1);
    next_bit   = bit_idx;
    next_shift = shift_reg;
    pop        = 1'b0;
    line_next  = 1'b1;
    case (state)
      ST_IDLE: begin
        next_cnt = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_shift = head;
          next_state = ST_START;
        end
      end
      ST_START: begin
        line_next = 1'b0;
        if (bit_done) begin
          next_state = ST_DATA;
          next_bit   = '0;
        end
      end
      ST_DATA: begin
        line_next = shift_reg[bit_idx];
        if (bit_done) begin
          if (bit_idx == 3'(DATA_W - 1)) begin
            next_bit = '0;
`ifdef UART_TX_PARITY_EN
            next_state = ST_PARITY;
`else
            next_state = ST_STOP;
`endif
          end else begin
            next_bit = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_next = ^shift_reg;
        if (bit_done) next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        line_next = 1'b1;
        if (bit_done) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: a transaction-level model predicts
// accepted bytes and occupancy; a line monitor decodes and checks frames.
module tb_uart_fifo_tx;

  localparam int FREQ  = 16;
  localparam int BAUD  = 1;
  localparam int DEPTH = 4;
  localparam int DIV   = FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] tx_data_byte;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       tx_ser_data_out;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic [2:0] fsm_state;

  uart_fifo_tx #(
    .SYSTM_OPERN_FREQ (FREQ),
    .REQD_BAUD_RATE   (BAUD),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .tx_data_byte    (tx_data_byte),
    .tx_data_valid   (tx_data_valid),
    .tx_data_ready   (tx_data_ready),
    .tx_ser_data_out (tx_ser_data_out),
    .tx_busy         (tx_busy),
    .fifo_count      (fifo_count),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- bookkeeping ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_done = 0;
  int         peak = 0;
  bit         checker_on = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes in the buffer plus the time the transmitter stays occupied per frame.
  int m_cnt   = 0;
  int m_timer = 0;
  bit m_acc, m_pop;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt   = 0;
      m_timer = 0;
      exp_q.delete();
    end else begin
      m_acc = tx_data_valid && (m_cnt < DEPTH);
      m_pop = (m_timer == 0) && (m_cnt > 0);
      if (m_acc) exp_q.push_back(tx_data_byte);
      if (m_timer > 0) m_timer--;
      if (m_pop) m_timer = NB * DIV;
      m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = (($countones(b) % 2) == 1);
`endif
    return f;
  endfunction

  // ---------------- per-cycle status checks ----------------
  always @(negedge clock) begin
    if (checker_on) begin
      check("ready", int'(tx_data_ready), int'(m_cnt < DEPTH));
      check("count", int'(fifo_count), m_cnt);
      check("busy", int'(tx_busy), int'((m_timer != 0) || (m_cnt != 0)));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  // ---------------- line monitor / scoreboard ----------------
  bit          in_frame = 0;
  bit          ghost = 0;
  bit          bit_err = 0;
  logic        bad_level;
  int          mon_idx = 0;
  int          mon_bit;
  logic [7:0]  cur_byte;
  logic [10:0] cur_bits;

  always @(negedge clock) begin
    if (reset) begin
      in_frame = 0;
      ghost    = 0;
      bit_err  = 0;
    end else begin
      if (!in_frame && tx_ser_data_out == 1'b0) begin
        in_frame = 1;
        mon_idx  = 0;
        bit_err  = 0;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          ghost = 1;
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=start_bit required=idle_line (t=%0t)", $time);
        end else begin
          ghost    = 0;
          cur_byte = exp_q.pop_front();
          cur_bits = frame_bits(cur_byte);
        end
      end
      if (in_frame) begin
        mon_bit = mon_idx / DIV;
        if (!ghost && tx_ser_data_out !== cur_bits[mon_bit] && !bit_err) begin
          bit_err   = 1;
          bad_level = tx_ser_data_out;
        end
        if (mon_idx % DIV == DIV - 1) begin
          if (!ghost) begin
            checks++;
            if (bit_err) begin
              failures++;
              $display("FAIL frame_bit byte=%02h bit=%0d actual=%0b required=%0b (t=%0t)",
                       cur_byte, mon_bit, bad_level, cur_bits[mon_bit], $time);
            end
          end
          bit_err = 0;
          if (mon_bit == NB - 1) begin
            in_frame = 0;
            frames_done++;
          end
        end
        mon_idx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [7:0] d);
    @(negedge clock);
    tx_data_valid = v;
    tx_data_byte  = d;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (!(exp_q.size() == 0 && m_cnt == 0 && m_timer == 0 && !in_frame) && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("drain_in_time", int'(n < limit), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int f0, s0, n;

  initial begin
    reset         = 1'b1;
    tx_data_valid = 1'b0;
    tx_data_byte  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_line", int'(tx_ser_data_out), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(tx_data_ready), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_state", int'(fsm_state), 0);
    reset      = 1'b0;
    checker_on = 1;
    repeat (2) @(negedge clock);

    // single byte with start-bit latency
    f0 = frames_done;
    set_in(1'b1, 8'hA5);
    set_in(1'b0, 8'h00);
    n = 0;
    while (tx_ser_data_out == 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("start_latency", n, 2);
    wait_drain(NB * DIV + 50);
    check("single_frames", frames_done - f0, 1);

    // burst of three on consecutive clocks
    f0 = frames_done;
    s0 = start_q.size();
    peak = 0;
    set_in(1'b1, 8'h00);
    set_in(1'b1, 8'hFF);
    set_in(1'b1, 8'h3C);
    set_in(1'b0, 8'h00);
    wait_drain(NB * DIV * 4);
    check("burst_frames", frames_done - f0, 3);
    check("burst_peak", peak, 2);
    if (start_q.size() >= s0 + 3) begin
      check("burst_gap1", start_q[s0+1] - start_q[s0], NB * DIV + 1);
      check("burst_gap2", start_q[s0+2] - start_q[s0+1], NB * DIV + 1);
    end else begin
      check("burst_starts", start_q.size() - s0, 3);
    end

    // parity-sensitive bytes
    set_in(1'b1, 8'h07);
    set_in(1'b1, 8'h03);
    set_in(1'b0, 8'h00);
    wait_drain(NB * DIV * 3);

    // full FIFO: one in flight, six offered, four kept
    f0 = frames_done;
    set_in(1'b1, 8'h11);
    set_in(1'b0, 8'h00);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      tx_data_valid = 1'b1;
      tx_data_byte  = 8'(8'h20 + i);
      check("full_ready", int'(tx_data_ready), (i < 4) ? 1 : 0);
    end
    set_in(1'b0, 8'h00);
    check("full_count", int'(fifo_count), 4);
    wait_drain(NB * DIV * 7);
    check("full_frames", frames_done - f0, 5);

    // push offered on a full FIFO at the same edge as a pop
    f0 = frames_done;
    for (int i = 0; i < 5; i++) set_in(1'b1, 8'(8'h31 + i));
    set_in(1'b1, 8'hEE);
    n = 0;
    while (fifo_count == 3'd4 && n < NB * DIV + 20) begin
      @(negedge clock);
      n++;
    end
    tx_data_valid = 1'b0;
    check("coinc_count", int'(fifo_count), 3);
    wait_drain(NB * DIV * 7);
    check("coinc_frames", frames_done - f0, 5);

    // reset during data bit 3
    f0 = frames_done;
    set_in(1'b1, 8'h55);
    set_in(1'b1, 8'h12);
    set_in(1'b0, 8'h00);
    n = 0;
    while (!(in_frame && mon_idx >= 4 * DIV + 6) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("reach_bit3", int'(n < 400), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_line", int'(tx_ser_data_out), 1);
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_busy", int'(tx_busy), 0);
    check("mid_rst_ready", int'(tx_data_ready), 1);
    check("mid_rst_state", int'(fsm_state), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (NB * DIV * 3) @(negedge clock);
    check("post_rst_frames", frames_done - f0, 0);

    // randomized traffic
    repeat (2500) begin
      @(negedge clock);
      tx_data_valid = ($urandom_range(0, 29) == 0);
      tx_data_byte  = 8'($urandom_range(0, 255));
    end
    set_in(1'b0, 8'h00);
    wait_drain(NB * DIV * (DEPTH + 3));
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
